// File: rtl/slot_alloc_pkg.sv
// -----------------------------------------------------------------------------
// slot_alloc_pkg
// Shared definitions for the slot allocator:
//   SIZE_DEFAULT  default number of tracked slots
//   idx_width()   slot index width for a given slot count
//   alloc_port_t  2-bit per-port request/grant vector
// -----------------------------------------------------------------------------
package slot_alloc_pkg;

  localparam int SIZE_DEFAULT = 16;

  typedef logic [1:0] alloc_port_t;

  function automatic int idx_width(input int size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/slot_allocator_find_zeros.sv
// -----------------------------------------------------------------------------
// find_zeros
// Purely combinational scan of an occupancy vector. It returns the lowest
// and second-lowest zero bit positions, with one found flag for each. When a
// position does not exist, its index is 0 and its flag is 0.
//
// Ports:
//   vec           occupancy vector (1 = allocated)
//   first_idx     index of the lowest zero
//   first_found   a lowest zero exists
//   second_idx    index of the second-lowest zero
//   second_found  a second-lowest zero exists
// -----------------------------------------------------------------------------
module find_zeros
  import slot_alloc_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic [SIZE-1:0]            vec,
  output logic [idx_width(SIZE)-1:0] first_idx,
  output logic                       first_found,
  output logic [idx_width(SIZE)-1:0] second_idx,
  output logic                       second_found
);

  localparam int IDXW = idx_width(SIZE);

  always_comb begin
    first_idx    = '0;
    first_found  = 1'b0;
    second_idx   = '0;
    second_found = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!vec[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = IDXW'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = IDXW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// -----------------------------------------------------------------------------
// slot_allocator
// Tracks the occupancy of SIZE slots. There are two allocation ports and two
// release ports. Each allocation port grants the lowest free slot still
// available. All state lives in this module. The find_zeros sub-module only
// supplies the candidate indices.
//
// Optional feature: define SLOT_ALLOC_ERR_EN to add the sticky 'err' output.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous, active-low reset
//   alloc_req  per-port request; bit 1 counts only together with bit 0
//   alloc_gnt  per-port grant, combinational from registered state
//   alloc_idx0 lowest free slot index (0 if none)
//   alloc_idx1 second-lowest free slot index (0 if none)
//   free_vld   per-port release strobe
//   free_idx0  slot released by port 0
//   free_idx1  slot released by port 1
//   busy_vec   registered occupancy, 1 = allocated
//   free_cnt   registered number of free slots
//   full       no free slots
//   empty      all slots free
//   err        (SLOT_ALLOC_ERR_EN only) sticky bad-release flag
// -----------------------------------------------------------------------------
module slot_allocator
  import slot_alloc_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 alloc_req,
  output logic [1:0]                 alloc_gnt,
  output logic [idx_width(SIZE)-1:0] alloc_idx0,
  output logic [idx_width(SIZE)-1:0] alloc_idx1,
  input  logic [1:0]                 free_vld,
  input  logic [idx_width(SIZE)-1:0] free_idx0,
  input  logic [idx_width(SIZE)-1:0] free_idx1,
  output logic [SIZE-1:0]            busy_vec,
  output logic [idx_width(SIZE):0]   free_cnt,
  output logic                       full,
  output logic                       empty
`ifdef SLOT_ALLOC_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int IDXW = idx_width(SIZE);
  localparam logic [IDXW:0] SIZE_W  = (IDXW+1)'(SIZE);
  localparam logic [IDXW:0] CNT_TWO = (IDXW+1)'(2);

  logic              first_found;
  logic              second_found;
  alloc_port_t       gnt;
  logic              rel0;
  logic              rel1;
  logic              in_range0;
  logic              in_range1;
  logic [SIZE-1:0]   busy_nxt;
  logic [IDXW:0]     cnt_nxt;

  find_zeros #(.SIZE(SIZE)) u_find_zeros (
    .vec          (busy_vec),
    .first_idx    (alloc_idx0),
    .first_found  (first_found),
    .second_idx   (alloc_idx1),
    .second_found (second_found)
  );

  // Grants are masked by rst_n so none are visible while reset is held.
  // free_cnt and the found flags always agree. The flags keep the grant
  // tied to a slot that actually exists.
  always_comb begin
    gnt    = '0;
    gnt[0] = rst_n && alloc_req[0] && (free_cnt != '0) && first_found;
    gnt[1] = rst_n && alloc_req[0] && alloc_req[1] &&
             (free_cnt >= CNT_TWO) && second_found;
  end

  assign alloc_gnt = gnt;

  // A release takes effect only when it names an in-range, busy slot.
  // If port 1 repeats port 0's effective release, it is a double-free and is dropped.
  assign in_range0 = ({1'b0, free_idx0} < SIZE_W);
  assign in_range1 = ({1'b0, free_idx1} < SIZE_W);

  always_comb begin
    rel0 = 1'b0;
    rel1 = 1'b0;
    if (free_vld[0] && in_range0)
      rel0 = busy_vec[free_idx0];
    if (free_vld[1] && in_range1)
      rel1 = busy_vec[free_idx1] && !(rel0 && (free_idx1 == free_idx0));
  end

  // Granted slots are currently free and released slots are currently busy,
  // so the set and clear operations never target the same bit.
  always_comb begin
    busy_nxt = busy_vec;
    if (gnt[0]) busy_nxt[alloc_idx0] = 1'b1;
    if (gnt[1]) busy_nxt[alloc_idx1] = 1'b1;
    if (rel0)   busy_nxt[free_idx0]  = 1'b0;
    if (rel1)   busy_nxt[free_idx1]  = 1'b0;
  end

  always_comb begin
    cnt_nxt = free_cnt
            - (IDXW+1)'(gnt[0]) - (IDXW+1)'(gnt[1])
            + (IDXW+1)'(rel0)   + (IDXW+1)'(rel1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      free_cnt <= SIZE_W;
    end else begin
      busy_vec <= busy_nxt;
      free_cnt <= cnt_nxt;
    end
  end

  assign full  = (free_cnt == '0);
  assign empty = (free_cnt == SIZE_W);

`ifdef SLOT_ALLOC_ERR_EN
  logic bad_release;

  // Any strobe that did not produce an effective release is an error. This
  // covers non-busy, out-of-range and double-free releases.
  assign bad_release = (free_vld[0] && !rel0) || (free_vld[1] && !rel1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (bad_release)
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_slot_allocator.sv
// -----------------------------------------------------------------------------
// tb_slot_allocator
// Self-checking bench for slot_allocator with SIZE=4.
// -----------------------------------------------------------------------------
module tb_slot_allocator;

  localparam int SIZE = 4;
  localparam int IDXW = 2;

  logic            clk;
  logic            rst_n;
  logic [1:0]      alloc_req;
  logic [1:0]      alloc_gnt;
  logic [IDXW-1:0] alloc_idx0;
  logic [IDXW-1:0] alloc_idx1;
  logic [1:0]      free_vld;
  logic [IDXW-1:0] free_idx0;
  logic [IDXW-1:0] free_idx1;
  logic [SIZE-1:0] busy_vec;
  logic [IDXW:0]   free_cnt;
  logic            full;
  logic            empty;
`ifdef SLOT_ALLOC_ERR_EN
  logic            err;
`endif

  slot_allocator #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_idx0 (alloc_idx0),
    .alloc_idx1 (alloc_idx1),
    .free_vld   (free_vld),
    .free_idx0  (free_idx0),
    .free_idx1  (free_idx1),
    .busy_vec   (busy_vec),
    .free_cnt   (free_cnt),
    .full       (full),
    .empty      (empty)
`ifdef SLOT_ALLOC_ERR_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      req;
    logic [1:0]      fvld;
    logic [IDXW-1:0] fi0;
    logic [IDXW-1:0] fi1;
    logic [1:0]      exp_gnt;
    logic [IDXW-1:0] exp_i0;
    logic [IDXW-1:0] exp_i1;
    logic [SIZE-1:0] exp_busy;
    logic [IDXW:0]   exp_cnt;
    logic            exp_err;
  } vec_t;

  typedef struct {
    logic [SIZE-1:0] busy;
    logic [IDXW:0]   cnt;
    logic            err;
  } state_t;

  state_t sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_t s);
    check({tag, " busy_vec"}, 32'(busy_vec), 32'(s.busy));
    check({tag, " free_cnt"}, 32'(free_cnt), 32'(s.cnt));
    check({tag, " full"},     32'(full),     32'(s.cnt == 0));
    check({tag, " empty"},    32'(empty),    32'(s.cnt == SIZE));
`ifdef SLOT_ALLOC_ERR_EN
    check({tag, " err"},      32'(err),      32'(s.err));
`endif
  endtask

  // One cycle: drive inputs after the falling edge, check the combinational
  // outputs, queue the expected next state, and check it after the rising edge.
  task automatic step(input string tag, input vec_t v);
    state_t exp_s;
    state_t got_s;
    @(negedge clk);
    alloc_req = v.req;
    free_vld  = v.fvld;
    free_idx0 = v.fi0;
    free_idx1 = v.fi1;
    #1;
    check({tag, " gnt"},  32'(alloc_gnt),  32'(v.exp_gnt));
    check({tag, " idx0"}, 32'(alloc_idx0), 32'(v.exp_i0));
    check({tag, " idx1"}, 32'(alloc_idx1), 32'(v.exp_i1));
    exp_s.busy = v.exp_busy;
    exp_s.cnt  = v.exp_cnt;
    exp_s.err  = v.exp_err;
    sb_q.push_back(exp_s);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: queue empty, expected one entry", tag);
    end else begin
      got_s = sb_q.pop_front();
      check_state(tag, got_s);
    end
  endtask

  task automatic idle_inputs();
    alloc_req = '0;
    free_vld  = '0;
    free_idx0 = '0;
    free_idx1 = '0;
  endtask

  task automatic do_reset();
    state_t r;
    @(negedge clk);
    idle_inputs();
    alloc_req = 2'b11;
    rst_n = 1'b0;
    #2;
    r.busy = '0; r.cnt = 3'(SIZE); r.err = 1'b0;
    check_state("reset", r);
    check("reset gnt", 32'(alloc_gnt), 32'h0);
    @(negedge clk);
    alloc_req = '0;
    rst_n = 1'b1;
  endtask

  vec_t tbl[12];
  vec_t v;
  state_t r;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    //            req    fvld   fi0 fi1 gnt    i0 i1 busy     cnt err
    tbl[0]  = '{2'b11, 2'b00, 0, 0, 2'b11, 0, 1, 4'b0011, 2, 0};
    tbl[1]  = '{2'b01, 2'b00, 0, 0, 2'b01, 2, 3, 4'b0111, 1, 0};
    tbl[2]  = '{2'b10, 2'b00, 0, 0, 2'b00, 3, 0, 4'b0111, 1, 0};
    tbl[3]  = '{2'b11, 2'b01, 0, 0, 2'b01, 3, 0, 4'b1110, 1, 0};
    tbl[4]  = '{2'b11, 2'b00, 0, 0, 2'b01, 0, 0, 4'b1111, 0, 0};
    tbl[5]  = '{2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 4'b1111, 0, 0};
    tbl[6]  = '{2'b01, 2'b11, 1, 2, 2'b00, 0, 0, 4'b1001, 2, 0};
    tbl[7]  = '{2'b00, 2'b00, 0, 0, 2'b00, 1, 2, 4'b1001, 2, 0};
    tbl[8]  = '{2'b00, 2'b11, 0, 0, 2'b00, 1, 2, 4'b1000, 3, 1};
    tbl[9]  = '{2'b11, 2'b11, 1, 3, 2'b11, 0, 1, 4'b0011, 2, 1};
    tbl[10] = '{2'b00, 2'b10, 0, 0, 2'b00, 2, 3, 4'b0010, 3, 1};
    tbl[11] = '{2'b11, 2'b01, 1, 0, 2'b11, 0, 2, 4'b0101, 2, 1};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // A release of a non-busy slot leaves state unchanged and sets err sticky.
    do_reset();
    v = '{2'b01, 2'b00, 0, 0, 2'b01, 0, 1, 4'b0001, 3, 0};
    step("nb_alloc", v);
    v = '{2'b00, 2'b01, 3, 0, 2'b00, 1, 2, 4'b0001, 3, 1};
    step("nb_free", v);
    v = '{2'b00, 2'b00, 0, 0, 2'b00, 1, 2, 4'b0001, 3, 1};
    step("nb_hold", v);
    step("nb_hold2", v);

    // Assert reset mid-operation between edges while busy_vec=0111.
    do_reset();
    v = '{2'b11, 2'b00, 0, 0, 2'b11, 0, 1, 4'b0011, 2, 0};
    step("mr_a", v);
    v = '{2'b01, 2'b00, 0, 0, 2'b01, 2, 3, 4'b0111, 1, 0};
    step("mr_b", v);
    @(negedge clk);
    alloc_req = 2'b11;
    free_vld  = 2'b01;
    free_idx0 = 1;
    #2;
    rst_n = 1'b0;
    #1;
    r.busy = '0; r.cnt = 3'(SIZE); r.err = 1'b0;
    check_state("midrst", r);
    check("midrst gnt", 32'(alloc_gnt), 32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    v = '{2'b01, 2'b00, 0, 0, 2'b01, 0, 1, 4'b0001, 3, 0};
    step("post_rst", v);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, meaning the number of tracked slots (legal range 4..64).
REQ-002 The block SHALL have localparam IDXW, value $clog2(SIZE), meaning the slot index width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port alloc_req, input, 2 bits: per-port allocation request; bit 1 is valid only with bit 0.
REQ-006 The block SHALL have port alloc_gnt, output, 2 bits: per-port grant, combinational from registered state.
REQ-007 The block SHALL have ports alloc_idx0 and alloc_idx1, output, IDXW bits each: granted slot indices.
REQ-008 The block SHALL have port free_vld, input, 2 bits: per-port release strobe.
REQ-009 The block SHALL have ports free_idx0 and free_idx1, input, IDXW bits each: slots to release.
REQ-010 The block SHALL have port busy_vec, output, SIZE bits: registered occupancy, where 1 means allocated.
REQ-011 The block SHALL have port free_cnt, output, IDXW+1 bits: registered count of zero bits in busy_vec.
REQ-012 The block SHALL have ports full and empty, output, 1 bit each: free_cnt==0 and free_cnt==SIZE respectively.

Function
REQ-013 alloc_idx0 SHALL be the lowest-index zero of busy_vec, and alloc_idx1 SHALL be the second-lowest zero; each SHALL be 0 when no such zero exists.
REQ-014 alloc_gnt[0] SHALL equal alloc_req[0] AND (free_cnt>=1); alloc_gnt[1] SHALL equal alloc_req[1] AND alloc_req[0] AND (free_cnt>=2).
REQ-015 alloc_req[1] asserted without alloc_req[0] SHALL be ignored, with no grant and no state change.
REQ-016 On a clock edge, each granted index SHALL be set in busy_vec, and each free_vld port whose index is currently busy SHALL clear that bit.
REQ-017 Slots released in cycle N SHALL NOT be grantable before cycle N+1 (no same-cycle bypass); this gives one-cycle release-to-reuse latency.
REQ-018 Both free ports naming the same busy index in one cycle SHALL clear it once; the port-1 release is treated as a double-free.
REQ-019 Releasing a non-busy slot, or an index >= SIZE, SHALL leave state unchanged.
REQ-020 free_cnt SHALL update each cycle as free_cnt - grants + effective releases, and SHALL never underflow or exceed SIZE.
REQ-021 Simultaneous grants and releases in one cycle SHALL all take effect in that cycle.

Reset
REQ-022 On rst_n low, asynchronously: busy_vec=0, free_cnt=SIZE, empty=1, full=0, and alloc_gnt=0 regardless of alloc_req.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight grants and releases; the first post-reset grant SHALL be index 0.

Configuration
REQ-024 With SLOT_ALLOC_ERR_EN defined, the block SHALL add output port err, 1 bit, sticky: set on any release of a non-busy or out-of-range index and on the REQ-018 double-free; cleared only by reset.
REQ-025 Without SLOT_ALLOC_ERR_EN, port err SHALL be absent and such releases SHALL be silently ignored.

Structure
REQ-026 Package slot_alloc_pkg SHALL hold the default SIZE, the IDXW computation function, and the alloc_port_t typedef (2-bit request/grant vector).
REQ-027 A combinational sub-module find_zeros (param SIZE) SHALL return the first and second zero indices and their found flags; the top-level holds all state.

Verification (SIZE=4)
REQ-028 Reset, then alloc_req=2'b11 -> gnt=11, idx0=0, idx1=1; next cycle busy_vec=0011, free_cnt=2.
REQ-029 busy_vec=1110, alloc_req=11 -> gnt=01, idx0=0; next cycle full=1, then a further alloc_req=01 -> gnt=00.
REQ-030 busy_vec=1111, free_vld=11 with idx 1 and 2, alloc_req=01 in the same cycle -> gnt=0; next cycle busy_vec=1001, idx0=1, idx1=2.
REQ-031 busy_vec=0001, free idx 3 (non-busy) -> busy_vec unchanged; with SLOT_ALLOC_ERR_EN, err=1 and stays 1 until rst_n is low.
REQ-032 alloc_req=10 only -> gnt=00 and state unchanged; then rst_n is pulsed low between edges while busy_vec=0111 -> immediately busy_vec=0, empty=1.
